// File: rtl/acc_pkg.sv
// Shared definitions for the operand accumulator stage:
// FSM state encoding and default batch geometry.
package acc_pkg;

    localparam int ACC_WIDTH = 8;
    localparam int ACC_N_OPS = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/acc_adder.sv
// WIDTH-bit combinational ripple adder.
// Ports: a, b (operands), cin (carry in) -> s (sum), cout (carry out).
module acc_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    always_comb begin
        {cout, s} = {1'b0, a}
                  + {1'b0, b}
                  + {{WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/operand_accumulator.sv
// Folds a batch of N_OPS operands into a running sum, counting carry-outs.
// Ports: start, in_valid/in_data/in_ready (operand stream),
//        out_valid/out_ready/out_sum/out_carries (result), busy.
module operand_accumulator
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int N_OPS = ACC_N_OPS,
    localparam int CW   = $clog2(N_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CW-1:0]    out_carries,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    carries;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum;
    logic             cout;

    acc_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // Handshake flags are registered alongside the state so
    // they change only on clock edges (or async reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            carries   <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        carries  <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc     <= sum;
                        carries <= carries + CW'(cout);
                        cnt     <= cnt + CW'(1);
                        if (cnt == CW'(N_OPS - 1)) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // start in this cycle is deliberately dropped
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_sum     = acc;
    assign out_carries = carries;

endmodule

// File: tb/tb_operand_accumulator.sv
// Directed self-checking bench for operand_accumulator
// (WIDTH=8, N_OPS=4) with hand-computed expectations.
module tb_operand_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [2:0] out_carries;
    logic       busy;

    int checks;
    int failures;

    operand_accumulator #(
        .WIDTH (8),
        .N_OPS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carries (out_carries),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one operand and hold it until it is accepted.
    task automatic send(input logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        #12;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_car", 32'(out_carries), 32'd0);
        rst_n = 1'b1;
        tick();

        // Batch 1, then hold result (backpressure, stray start)
        do_start();
        chk("t1_ir", 32'(in_ready), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        send(8'hDA);
        send(8'h65);
        send(8'h9B);
        chk("t1_ov_early", 32'(out_valid), 32'd0);
        send(8'h6D);
        chk("t1_ov", 32'(out_valid), 32'd1);
        chk("t1_sum", 32'(out_sum), 32'h47);
        chk("t1_car", 32'(out_carries), 32'd2);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            chk("t4_ov", 32'(out_valid), 32'd1);
            chk("t4_sum", 32'(out_sum), 32'h47);
            chk("t4_car", 32'(out_carries), 32'd2);
            chk("t4_ir", 32'(in_ready), 32'd0);
        end
        start = 1'b0;
        drain("t4");

        // Batch 2: all ones
        do_start();
        for (int i = 0; i < 4; i++) send(8'hFF);
        chk("t2_ov", 32'(out_valid), 32'd1);
        chk("t2_sum", 32'(out_sum), 32'hFC);
        chk("t2_car", 32'(out_carries), 32'd3);
        drain("t2");

        // Batch 3: zeros with idle gaps
        do_start();
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g <= (i % 3); g++) begin
                tick();
                chk("t3_ir_gap", 32'(in_ready), 32'd1);
                chk("t3_ov_gap", 32'(out_valid), 32'd0);
            end
            send(8'h00);
        end
        chk("t3_ov", 32'(out_valid), 32'd1);
        chk("t3_sum", 32'(out_sum), 32'h00);
        chk("t3_car", 32'(out_carries), 32'd0);
        drain("t3");

        // Async reset mid-batch
        do_start();
        send(8'hDA);
        send(8'h65);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_sum", 32'(out_sum), 32'd0);
        chk("t5_car", 32'(out_carries), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ir", 32'(in_ready), 32'd0);
        chk("t5_ov", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_idle", 32'(busy), 32'd0);
        do_start();
        send(8'hDA);
        send(8'h65);
        send(8'h9B);
        send(8'h6D);
        chk("t5_re_sum", 32'(out_sum), 32'h47);
        chk("t5_re_car", 32'(out_carries), 32'd2);
        drain("t5");

        // Stray start in ACCUM and together with out_ready
        do_start();
        send(8'h10);
        send(8'h20);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_ir", 32'(in_ready), 32'd1);
        send(8'h30);
        send(8'h40);
        chk("t6_ov", 32'(out_valid), 32'd1);
        chk("t6_sum", 32'(out_sum), 32'hA0);
        chk("t6_car", 32'(out_carries), 32'd0);
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        chk("t6_ov_drop", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        tick();
        chk("t6_stay_idle", 32'(busy), 32'd0);
        chk("t6_stay_ir", 32'(in_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
